// File: rtl/burst_slave_port.sv
// Serial-bus slave endpoint: deserialises an address/length request, then
// streams a burst of data beats to or from one slave memory instance.
module burst_slave_port #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LEN_WIDTH   = 2,
    parameter int unsigned MEM_DEPTH   = 2048,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] smemrdata,
    output logic                  smemwen,
    output logic                  smemren,
    output logic [ADDR_WIDTH-1:0] smemaddr,
    output logic [DATA_WIDTH-1:0] smemwdata,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sbusy,
    output logic                  sdone,
    output logic                  serr
);

    localparam int unsigned REQ_WIDTH = ADDR_WIDTH + LEN_WIDTH;
    localparam int unsigned REQ_CW    = $clog2(REQ_WIDTH + 1);
    localparam int unsigned BIT_CW    = $clog2(DATA_WIDTH + 1);
    localparam int unsigned LAT_CW    = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WDATA = 3'd2,
        RREQ  = 3'd3,
        RWAIT = 3'd4,
        RSEND = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic [REQ_WIDTH-2:0]    req_sh, req_sh_nxt;
    logic [REQ_CW-1:0]       req_cnt, req_cnt_nxt;
    logic                    mode, mode_nxt;
    logic [LEN_WIDTH-1:0]    len, len_nxt;
    logic [LEN_WIDTH-1:0]    beat, beat_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_nxt;
    logic                    oor, oor_nxt;
    logic [BIT_CW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-2:0]   wsh, wsh_nxt;
    logic [DATA_WIDTH-2:0]   rsh, rsh_nxt;
    logic [LAT_CW-1:0]       lat_cnt, lat_cnt_nxt;
    logic                    skip, skip_nxt;

    logic                    smemwen_nxt, smemren_nxt;
    logic [ADDR_WIDTH-1:0]   smemaddr_nxt;
    logic [DATA_WIDTH-1:0]   smemwdata_nxt;
    logic                    srdata_nxt, svalid_nxt, sbusy_nxt, sdone_nxt, serr_nxt;

    logic [REQ_WIDTH-1:0]    req_full;
    logic [DATA_WIDTH-1:0]   wword;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    req_in_range, cur_in_range, next_in_range;
    logic                    req_last, bit_last, beat_last;

    // Assembled words including the bit currently on swdata
    assign req_full      = {swdata, req_sh};
    assign wword         = {swdata, wsh};
    assign next_addr     = cur_addr + ADDR_WIDTH'(1);
    assign req_in_range  = {1'b0, req_full[ADDR_WIDTH-1:0]} < DEPTH_LIM;
    assign cur_in_range  = {1'b0, cur_addr} < DEPTH_LIM;
    assign next_in_range = {1'b0, next_addr} < DEPTH_LIM;
    assign req_last      = (req_cnt == REQ_CW'(REQ_WIDTH - 1));
    assign bit_last      = (bit_cnt == BIT_CW'(DATA_WIDTH - 1));
    assign beat_last     = (beat == len);

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            req_sh    <= '0;
            req_cnt   <= '0;
            mode      <= 1'b0;
            len       <= '0;
            beat      <= '0;
            cur_addr  <= '0;
            oor       <= 1'b0;
            bit_cnt   <= '0;
            wsh       <= '0;
            rsh       <= '0;
            lat_cnt   <= '0;
            skip      <= 1'b0;
            smemwen   <= 1'b0;
            smemren   <= 1'b0;
            smemaddr  <= '0;
            smemwdata <= '0;
            srdata    <= 1'b0;
            svalid    <= 1'b0;
            sbusy     <= 1'b0;
            sdone     <= 1'b0;
            serr      <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_sh    <= req_sh_nxt;
            req_cnt   <= req_cnt_nxt;
            mode      <= mode_nxt;
            len       <= len_nxt;
            beat      <= beat_nxt;
            cur_addr  <= cur_addr_nxt;
            oor       <= oor_nxt;
            bit_cnt   <= bit_cnt_nxt;
            wsh       <= wsh_nxt;
            rsh       <= rsh_nxt;
            lat_cnt   <= lat_cnt_nxt;
            skip      <= skip_nxt;
            smemwen   <= smemwen_nxt;
            smemren   <= smemren_nxt;
            smemaddr  <= smemaddr_nxt;
            smemwdata <= smemwdata_nxt;
            srdata    <= srdata_nxt;
            svalid    <= svalid_nxt;
            sbusy     <= sbusy_nxt;
            sdone     <= sdone_nxt;
            serr      <= serr_nxt;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt     = state;
        req_sh_nxt    = req_sh;
        req_cnt_nxt   = req_cnt;
        mode_nxt      = mode;
        len_nxt       = len;
        beat_nxt      = beat;
        cur_addr_nxt  = cur_addr;
        oor_nxt       = oor;
        bit_cnt_nxt   = bit_cnt;
        wsh_nxt       = wsh;
        rsh_nxt       = rsh;
        lat_cnt_nxt   = lat_cnt;
        skip_nxt      = 1'b0;
        smemwen_nxt   = 1'b0;
        smemren_nxt   = 1'b0;
        smemaddr_nxt  = smemaddr;
        smemwdata_nxt = smemwdata;
        srdata_nxt    = srdata;
        svalid_nxt    = svalid;
        sdone_nxt     = 1'b0;
        serr_nxt      = 1'b0;

        case (state)
            IDLE: begin
                // One quiet cycle after a completed transaction
                if (mvalid && !skip) begin
                    state_nxt   = REQ;
                    mode_nxt    = smode;
                    req_sh_nxt  = req_full[REQ_WIDTH-1:1];
                    req_cnt_nxt = REQ_CW'(1);
                end
            end

            REQ: begin
                if (!mvalid) begin
                    state_nxt = IDLE;
                    serr_nxt  = 1'b1;
                end else if (req_last) begin
                    cur_addr_nxt = req_full[ADDR_WIDTH-1:0];
                    len_nxt      = req_full[REQ_WIDTH-1:ADDR_WIDTH];
                    beat_nxt     = '0;
                    bit_cnt_nxt  = '0;
                    if (mode) begin
                        state_nxt = WDATA;
                    end else begin
                        state_nxt = RREQ;
                        if (req_in_range) begin
                            smemren_nxt  = 1'b1;
                            smemaddr_nxt = req_full[ADDR_WIDTH-1:0];
                            oor_nxt      = 1'b0;
                        end else begin
                            serr_nxt = 1'b1;
                            oor_nxt  = 1'b1;
                        end
                    end
                end else begin
                    req_sh_nxt  = req_full[REQ_WIDTH-1:1];
                    req_cnt_nxt = req_cnt + REQ_CW'(1);
                end
            end

            WDATA: begin
                // mvalid low simply stalls collection
                if (mvalid) begin
                    wsh_nxt = wword[DATA_WIDTH-1:1];
                    if (bit_last) begin
                        bit_cnt_nxt = '0;
                        if (cur_in_range) begin
                            smemwen_nxt   = 1'b1;
                            smemaddr_nxt  = cur_addr;
                            smemwdata_nxt = wword;
                        end else begin
                            serr_nxt = 1'b1;
                        end
                        if (beat_last) begin
                            state_nxt = IDLE;
                            sdone_nxt = 1'b1;
                            skip_nxt  = 1'b1;
                        end else begin
                            beat_nxt     = beat + LEN_WIDTH'(1);
                            cur_addr_nxt = next_addr;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CW'(1);
                    end
                end
            end

            RREQ: begin
                lat_cnt_nxt = LAT_CW'(MEM_LATENCY - 1);
                state_nxt   = RWAIT;
            end

            RWAIT: begin
                // Capture read data (zero for an out-of-range beat) and start sending
                if (lat_cnt == '0) begin
                    rsh_nxt     = oor ? '0 : smemrdata[DATA_WIDTH-1:1];
                    srdata_nxt  = oor ? 1'b0 : smemrdata[0];
                    svalid_nxt  = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = RSEND;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_CW'(1);
                end
            end

            RSEND: begin
                if (bit_last) begin
                    svalid_nxt  = 1'b0;
                    srdata_nxt  = 1'b0;
                    bit_cnt_nxt = '0;
                    if (beat_last) begin
                        state_nxt = IDLE;
                        sdone_nxt = 1'b1;
                        skip_nxt  = 1'b1;
                    end else begin
                        state_nxt    = RREQ;
                        beat_nxt     = beat + LEN_WIDTH'(1);
                        cur_addr_nxt = next_addr;
                        if (next_in_range) begin
                            smemren_nxt  = 1'b1;
                            smemaddr_nxt = next_addr;
                            oor_nxt      = 1'b0;
                        end else begin
                            serr_nxt = 1'b1;
                            oor_nxt  = 1'b1;
                        end
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + BIT_CW'(1);
                    srdata_nxt  = rsh[0];
                    rsh_nxt     = rsh >> 1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        sbusy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_burst_slave_port.sv
// Scoreboard bench for burst_slave_port: three instances (default, full-depth,
// three-cycle memory latency) share stimulus; sel picks the one being observed.
module tb_burst_slave_port;

    logic clk = 1'b0;
    logic rstn;
    logic swdata, smode, mvalid;

    always #5 clk = ~clk;

    logic        wen [3];
    logic        ren [3];
    logic        srd [3];
    logic        sv  [3];
    logic        busy[3];
    logic        done[3];
    logic        err [3];
    logic [11:0] maddr[3];
    logic [7:0]  wdat [3];
    logic [7:0]  rdat [3];

    burst_slave_port #(.MEM_DEPTH(2048), .MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .smemrdata(rdat[0]), .smemwen(wen[0]), .smemren(ren[0]),
        .smemaddr(maddr[0]), .smemwdata(wdat[0]), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srd[0]), .svalid(sv[0]), .sbusy(busy[0]), .sdone(done[0]), .serr(err[0]));

    burst_slave_port #(.MEM_DEPTH(4096), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .smemrdata(rdat[1]), .smemwen(wen[1]), .smemren(ren[1]),
        .smemaddr(maddr[1]), .smemwdata(wdat[1]), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srd[1]), .svalid(sv[1]), .sbusy(busy[1]), .sdone(done[1]), .serr(err[1]));

    burst_slave_port #(.MEM_DEPTH(2048), .MEM_LATENCY(3)) u_dut2 (
        .clk(clk), .rstn(rstn), .smemrdata(rdat[2]), .smemwen(wen[2]), .smemren(ren[2]),
        .smemaddr(maddr[2]), .smemwdata(wdat[2]), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srd[2]), .svalid(sv[2]), .sbusy(busy[2]), .sdone(done[2]), .serr(err[2]));

    // Memory models: mem[i] = i[7:0]; data is valid only in its latency slot
    logic       vq[3][3];
    logic [7:0] dq[3][3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            vq[k][0] <= ren[k];
            dq[k][0] <= maddr[k][7:0];
            for (int j = 1; j < 3; j++) begin
                vq[k][j] <= vq[k][j-1];
                dq[k][j] <= dq[k][j-1];
            end
        end
    end
    assign rdat[0] = vq[0][0] ? dq[0][0] : 8'hEE;
    assign rdat[1] = vq[1][0] ? dq[1][0] : 8'hEE;
    assign rdat[2] = vq[2][2] ? dq[2][2] : 8'hEE;

    int          sel = 0;
    logic        o_wen, o_ren, o_srd, o_sv, o_busy, o_done, o_err;
    logic [11:0] o_addr;
    logic [7:0]  o_wdata;
    always_comb begin
        o_wen   = wen[sel];
        o_ren   = ren[sel];
        o_srd   = srd[sel];
        o_sv    = sv[sel];
        o_busy  = busy[sel];
        o_done  = done[sel];
        o_err   = err[sel];
        o_addr  = maddr[sel];
        o_wdata = wdat[sel];
    end

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
        logic        done;
    } wr_t;

    wr_t         exp_wr[$];
    logic [11:0] exp_ren[$];
    logic [7:0]  exp_rd[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e_cyc = 0;
    int exp_lat = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int bitn = 0;
    logic lat_en = 1'b0;
    logic rd_mode = 1'b0;
    logic prev_sv = 1'b0;
    logic [7:0] rx = 8'h00;
    wr_t  wpop;
    logic [11:0] apop;
    logic [7:0]  dpop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations as the observed DUT produces output
    always @(negedge clk) begin
        if (!rstn) begin
            bitn    = 0;
            prev_sv = 1'b0;
        end else begin
            if (o_wen) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(1), 32'(0));
                else begin
                    wpop = exp_wr.pop_front();
                    check("wr_addr", 32'(o_addr), 32'(wpop.a));
                    check("wr_data", 32'(o_wdata), 32'(wpop.d));
                    check("wr_done_with_strobe", 32'(o_done), 32'(wpop.done));
                end
            end
            if (o_ren) begin
                if (exp_ren.size() == 0) check("rd_unexpected", 32'(1), 32'(0));
                else begin
                    apop = exp_ren.pop_front();
                    check("rd_addr", 32'(o_addr), 32'(apop));
                end
            end
            if (o_sv) begin
                if (!prev_sv && lat_en) begin
                    check("rd_latency", 32'(cyc - e_cyc), 32'(exp_lat));
                    lat_en = 1'b0;
                end
                rx = {o_srd, rx[7:1]};
                bitn++;
                if (bitn == 8) begin
                    if (exp_rd.size() == 0) check("rd_beat_unexpected", 32'(1), 32'(0));
                    else begin
                        dpop = exp_rd.pop_front();
                        check("rd_data", 32'(rx), 32'(dpop));
                    end
                    bitn = 0;
                end
            end else if (bitn != 0) begin
                check("svalid_contig", 32'(bitn), 32'(0));
                bitn = 0;
            end
            if (o_done) begin
                done_cnt++;
                if (rd_mode) check("rd_done_after_last_bit", 32'(prev_sv), 32'(1));
            end
            if (o_err) err_cnt++;
            prev_sv = o_sv;
        end
    end

    task automatic do_reset();
        rstn = 1'b0; mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_wr.delete(); exp_ren.delete(); exp_rd.delete();
        done_cnt = 0; err_cnt = 0; lat_en = 1'b0; rd_mode = 1'b0;
    endtask

    // Request frame, LSB first; smode flips after the first bit and must be ignored
    task automatic send_req(input logic mode, input logic [11:0] a, input logic [1:0] len, input int nbits);
        logic [13:0] f;
        f = {len, a};
        for (int i = 0; i < nbits; i++) begin
            mvalid = 1'b1;
            swdata = f[i];
            smode  = (i == 0) ? mode : ~mode;
            @(posedge clk);
            #1;
        end
        e_cyc  = cyc;
        mvalid = 1'b0;
        swdata = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int stall_at);
        for (int i = 0; i < 8; i++) begin
            mvalid = 1'b1;
            swdata = d[i];
            @(posedge clk);
            #1;
            if (i == stall_at) begin
                mvalid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
        end
        mvalid = 1'b0;
    endtask

    task automatic end_txn(input string tag, input int exp_done, input int exp_err);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!o_busy) ok = 1'b1;
        end
        check({tag, "_idle"}, 32'(ok), 32'(1));
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'(0));
        check({tag, "_ren_left"}, 32'(exp_ren.size()), 32'(0));
        check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'(0));
        #1;
    endtask

    task automatic do_write(input string tag, input logic [11:0] a, input logic [1:0] len,
                            input logic [31:0] dw, input int stall_beat, input int depth);
        wr_t w;
        logic [11:0] an;
        int nerr;
        nerr = 0;
        done_cnt = 0; err_cnt = 0;
        for (int n = 0; n <= int'(len); n++) begin
            an = a + 12'(n);
            if (int'(an) < depth) begin
                w.a = an; w.d = dw[8*n +: 8]; w.done = (n == int'(len));
                exp_wr.push_back(w);
            end else nerr++;
        end
        send_req(1'b1, a, len, 14);
        for (int n = 0; n <= int'(len); n++)
            send_byte(dw[8*n +: 8], (n == stall_beat) ? 3 : -1);
        end_txn(tag, 1, nerr);
    endtask

    task automatic do_read(input string tag, input logic [11:0] a, input logic [1:0] len,
                           input int depth, input int lat);
        logic [11:0] an;
        int nerr;
        nerr = 0;
        done_cnt = 0; err_cnt = 0;
        for (int n = 0; n <= int'(len); n++) begin
            an = a + 12'(n);
            if (int'(an) < depth) begin
                exp_ren.push_back(an);
                exp_rd.push_back(an[7:0]);
            end else begin
                exp_rd.push_back(8'h00);
                nerr++;
            end
        end
        rd_mode = 1'b1;
        exp_lat = 1 + lat;
        send_req(1'b0, a, len, 14);
        lat_en = 1'b1;
        end_txn(tag, 1, nerr);
        rd_mode = 1'b0;
        lat_en  = 1'b0;
    endtask

    initial begin
        logic ok;
        rstn = 1'b0; mvalid = 1'b0; swdata = 1'b0; smode = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wen",   32'(o_wen),   32'(0));
        check("rst_ren",   32'(o_ren),   32'(0));
        check("rst_addr",  32'(o_addr),  32'(0));
        check("rst_wdata", 32'(o_wdata), 32'(0));
        check("rst_srdata",32'(o_srd),   32'(0));
        check("rst_svalid",32'(o_sv),    32'(0));
        check("rst_busy",  32'(o_busy),  32'(0));
        check("rst_done",  32'(o_done),  32'(0));
        check("rst_err",   32'(o_err),   32'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        do_reset(); sel = 0;
        do_write("wr1", 12'h005, 2'd0, 32'h0000_00A5, -1, 2048);

        do_reset(); sel = 0;
        do_read("rd4", 12'h010, 2'd3, 2048, 1);

        do_reset(); sel = 1;
        do_write("wrwrap", 12'hFFF, 2'd1, 32'h0000_C33C, 0, 4096);

        do_reset(); sel = 0;
        do_read("rdoor", 12'h900, 2'd0, 2048, 1);

        do_reset(); sel = 0;
        do_read("rdedge", 12'h7FF, 2'd1, 2048, 1);

        do_reset(); sel = 0;
        do_write("wredge", 12'h7FE, 2'd3, 32'h4433_2211, 2, 2048);

        do_reset(); sel = 0;
        done_cnt = 0; err_cnt = 0;
        send_req(1'b1, 12'h123, 2'd0, 5);
        end_txn("abort", 0, 1);
        do_write("after_abort", 12'h123, 2'd0, 32'h0000_005A, -1, 2048);

        // Reset while bit 3 of a read beat is on the wire
        do_reset(); sel = 0;
        exp_ren.push_back(12'h040);
        send_req(1'b0, 12'h040, 2'd0, 14);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (o_sv) ok = 1'b1;
        end
        check("rstmid_svalid_seen", 32'(ok), 32'(1));
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        done_cnt = 0; err_cnt = 0;
        @(negedge clk);
        check("rstmid_svalid", 32'(o_sv),   32'(0));
        check("rstmid_busy",   32'(o_busy), 32'(0));
        check("rstmid_done",   32'(o_done), 32'(0));
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid_no_done", 32'(done_cnt), 32'(0));
        check("rstmid_no_err",  32'(err_cnt),  32'(0));
        check("rstmid_idle",    32'(o_busy),   32'(0));

        do_reset(); sel = 2;
        do_read("rdlat3", 12'h020, 2'd1, 2048, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
